// File: rtl/fpu_addsub_seq.sv
// fpu_addsub_seq: multi-cycle IEEE-style add/subtract with flush-to-zero inputs,
// round-to-nearest-even, and valid/ready handshakes on operands and result.
// Flow: IDLE -> ALIGN -> ADD -> NORM (iterative, one bit per cycle) -> ROUND -> DONE.
`timescale 1ns/1ps
module fpu_addsub_seq #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   a,
  input  logic [EW+MW:0]   b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   z,
  output logic             ovf,
  output logic             unf,
  output logic             inv,
  output logic [2:0]       state_out
);

  localparam int W    = 1 + EW + MW;
  localparam int XW   = EW + 2;          // internal exponent, never wraps
  localparam int MAW  = MW + 5;          // {carry, hidden, frac, G, R, S}
  localparam int EMAX = (1 << EW) - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [W-1:0] NAN_Z = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  state_t           state_q;
  logic [W-1:0]     a_q, b_q;
  logic             sb_q;              // effective sign of b (sub applied)
  logic             sign_q;            // result sign = sign of larger magnitude
  logic             sub_q;             // effective operation is a subtraction
  logic [XW-1:0]    exp_q;
  logic [MAW-1:0]   ma_q, mb_q;        // ma_q doubles as the working mantissa after ADD
  logic [W-1:0]     z_q;
  logic             ovf_q, unf_q, inv_q;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign z         = z_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign inv       = inv_q;
  assign state_out = state_q;

  // Operand classification, magnitude ordering and alignment of the smaller operand
  logic             sa;
  logic [EW-1:0]    ea_f, eb_f, big_e, sml_e;
  logic [MW-1:0]    fa_f, fb_f, big_f, sml_f;
  logic             a_zero, b_zero, a_inf, b_inf, a_big, big_s;
  logic [31:0]      d;
  logic [MAW-1:0]   full_b, mask_b, al_a, al_b;
  always_comb begin
    sa     = a_q[W-1];
    ea_f   = a_q[W-2:MW];
    eb_f   = b_q[W-2:MW];
    fa_f   = a_q[MW-1:0];
    fb_f   = b_q[MW-1:0];
    a_zero = (ea_f == '0);
    b_zero = (eb_f == '0);
    a_inf  = (ea_f == '1);
    b_inf  = (eb_f == '1);
    a_big  = ({ea_f, fa_f} >= {eb_f, fb_f});
    big_e  = a_big ? ea_f : eb_f;
    sml_e  = a_big ? eb_f : ea_f;
    big_f  = a_big ? fa_f : fb_f;
    sml_f  = a_big ? fb_f : fa_f;
    big_s  = a_big ? sa : sb_q;
    d      = 32'(big_e) - 32'(sml_e);
    al_a   = {2'b01, big_f, 3'b000};
    full_b = {2'b01, sml_f, 3'b000};
    mask_b = '0;
    if (d >= 32'(MW + 3)) begin
      // everything lands below S: only the sticky survives
      al_b = MAW'(1);
    end else begin
      mask_b = (MAW'(1) << d) - MAW'(1);
      al_b   = (full_b >> d) | MAW'(|(full_b & mask_b));
    end
  end

  // Mantissa add/subtract; ordering guarantees the difference is non-negative
  logic [MAW-1:0] sum;
  always_comb begin
    sum = sub_q ? (ma_q - mb_q) : (ma_q + mb_q);
  end

  // Round-to-nearest-even on the normalised mantissa, with post-round renormalise
  logic            rinc, rco;
  logic [MW+1:0]   rnd;
  logic [MW-1:0]   rfrac;
  logic [XW-1:0]   rexp;
  always_comb begin
    rinc  = ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]);
    rnd   = ma_q[MAW-1:3] + (MW+2)'(rinc);
    rco   = rnd[MW+1];
    rfrac = rco ? rnd[MW:1] : rnd[MW-1:0];
    rexp  = exp_q + XW'(rco);
  end

  // Control FSM with registered result and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sb_q    <= 1'b0;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            sb_q    <= b[W-1] ^ sub;
            state_q <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          ovf_q <= 1'b0;
          unf_q <= 1'b0;
          inv_q <= 1'b0;
          if (a_inf || b_inf) begin
            if (a_inf && b_inf && (sa != sb_q)) begin
              z_q   <= NAN_Z;
              inv_q <= 1'b1;
            end else if (a_inf) begin
              z_q <= {sa, {EW{1'b1}}, {MW{1'b0}}};
            end else begin
              z_q <= {sb_q, {EW{1'b1}}, {MW{1'b0}}};
            end
            state_q <= S_DONE;
          end else if (a_zero && b_zero) begin
            z_q     <= {sa & sb_q, {(W-1){1'b0}}};
            state_q <= S_DONE;
          end else if (a_zero) begin
            z_q     <= {sb_q, b_q[W-2:0]};
            state_q <= S_DONE;
          end else if (b_zero) begin
            z_q     <= a_q;
            state_q <= S_DONE;
          end else begin
            sign_q  <= big_s;
            sub_q   <= sa ^ sb_q;
            exp_q   <= XW'(big_e);
            ma_q    <= al_a;
            mb_q    <= al_b;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          if (sum == '0) begin
            z_q     <= '0;
            state_q <= S_DONE;
          end else begin
            ma_q    <= sum;
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (ma_q[MAW-1]) begin
            // carry out: the right shift always leaves the hidden bit set
            ma_q    <= {1'b0, ma_q[MAW-1:2], ma_q[1] | ma_q[0]};
            exp_q   <= exp_q + XW'(1);
            state_q <= S_ROUND;
          end else if (!ma_q[MAW-2]) begin
            if (exp_q > XW'(1)) begin
              ma_q  <= {ma_q[MAW-2:0], 1'b0};
              exp_q <= exp_q - XW'(1);
            end else begin
              z_q     <= {sign_q, {(W-1){1'b0}}};
              unf_q   <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          if (rexp >= XW'(EMAX)) begin
            z_q   <= {sign_q, {EW{1'b1}}, {MW{1'b0}}};
            ovf_q <= 1'b1;
          end else begin
            z_q <= {sign_q, rexp[EW-1:0], rfrac};
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Scoreboard bench for fpu_addsub_seq (binary32): directed vectors with
// hand-computed results; a monitor checks z, flags and latency per result.
`timescale 1ns/1ps
module tb_fpu_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] z;
  logic        ovf, unf, inv;
  logic [2:0]  state_out;

  fpu_addsub_seq #(.EW(8), .MW(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .ovf(ovf), .unf(unf), .inv(inv), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] z;
    logic [2:0]  f;     // {ovf, unf, inv}
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
  endtask

  // Monitor: compare each presented result once against the scoreboard head
  logic seen = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sbq.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got z=%h with empty scoreboard", z);
      end else begin
        me = sbq.pop_front();
        chk("z", z, me.z);
        chk("flags", {29'd0, ovf, unf, inv}, {29'd0, me.f});
        chk("latency", 32'(cyc - acc_cyc), 32'(me.lat));
      end
    end else if (!out_valid) begin
      seen = 1'b0;
    end
  end

  // Push expectation, present operands for one edge while idle
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                       input logic [31:0] ez, input logic [2:0] ef, input int el);
    sbq.push_back('{z: ez, f: ef, lat: el});
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    @(posedge clk);
    #1 acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, counting cycles spent in NORM
  task automatic wait_out(output int nn);
    int k;
    nn = 0;
    for (k = 0; k < 200 && !out_valid; k++) begin
      @(negedge clk);
      if (state_out == 3'd3) nn++;
    end
    if (!out_valid) begin
      n_chk++;
      $display("FAIL timeout: out_valid %0b expected 1 within 200 cycles", out_valid);
    end
  endtask

  task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                     input logic [31:0] ez, input logic [2:0] ef, input int el);
    int nn;
    issue(ia, ib, is, ez, ef, el);
    wait_out(nn);
    @(negedge clk);  // handshake edge passed, back in IDLE
  endtask

  initial begin
    int nn;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, 0 expected");
    $fatal(1, "watchdog");
  end

  initial begin
    int nn;
    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", {29'd0, state_out}, 32'd0);
    chk("rst_z", z, 32'h0);
    chk("rst_flags", {29'd0, ovf, unf, inv}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // main vectors: a, b, sub, expected z, {ovf,unf,inv}, latency
    run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);   // 1+1
    run(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 2);   // 1-1
    run(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000, 4);   // tie, even
    run(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000, 4);   // tie, odd
    run(32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000, 4);   // 3 + -1
    run(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 4);   // overflow
    run(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001, 1);   // inf-inf
    run(32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 3'b000, 1);   // 0 + -3
    run(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 1);   // -0 - +0
    run(32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010, 3);   // underflow flush

    // long normalisation: 23 left shifts
    issue(32'h3FC00000, 32'h3FBFFFFF, 1'b1, 32'h34000000, 3'b000, 27);
    wait_out(nn);
    chk("norm_cycles", 32'(nn), 32'd24);
    @(negedge clk);

    // stall in DONE with out_ready low; new operands must be ignored
    out_ready = 1'b0;
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
    wait_out(nn);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; sub = 1'b0; in_valid = 1'b1;
      chk("stall_z", z, 32'h40000000);
      chk("stall_valid_ready", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_idle", {29'd0, state_out}, 32'd0);
    @(negedge clk);
    chk("release_no_accept", {29'd0, state_out}, 32'd0);

    // reset in the middle of normalisation
    issue(32'h3FC00000, 32'h3FBFFFFF, 1'b1, 32'h34000000, 3'b000, 27);
    for (int k = 0; k < 50 && state_out != 3'd3; k++) @(negedge clk);
    chk("reached_norm", {29'd0, state_out}, 32'd3);
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("arst_state", {29'd0, state_out}, 32'd0);
    chk("arst_z", z, 32'h0);
    chk("arst_flags", {29'd0, ovf, unf, inv}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
